// File: rtl/latch_load_sequencer.sv
// latch_load_sequencer
// Feeds the D-latch bank. It accepts one byte per valid/ready handshake and
// drives it on d_out. A single EN pulse is framed by a setup window and a
// hold window, so the latches never see data move while they are transparent.
module latch_load_sequencer #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             EN,
  output logic             busy,
  output logic [CNT_W-1:0] load_count
);

  // One shared down-counter times all three windows, so it is sized for the longest.
  localparam int MAXC = (SETUP_CYC > PULSE_CYC) ?
                        ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                        ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               en_q, en_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign in_ready   = (state_q == IDLE) && !rst;
  assign busy       = (state_q != IDLE);
  assign d_out      = dout_q;
  assign EN         = en_q;
  assign load_count = cnt_q;

  // Next-state logic: accept in IDLE, then step through the setup, pulse and hold windows.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    dout_d  = dout_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          dout_d  = d_in;
          tmr_d   = SETUP_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tmr_q == '0) begin
          en_d    = 1'b1;
          tmr_d   = PULSE_LD;
          state_d = PULSE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      PULSE: begin
        if (tmr_q == '0) begin
          en_d    = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          tmr_d   = HOLD_LD;
          state_d = HOLD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      HOLD: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight byte and drops EN immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      dout_q  <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_latch_load_sequencer.sv
// Bench for latch_load_sequencer: three instances (default timing, a 3/1/2
// timing sweep, and a 4-bit load counter), a timing model per instance, and
// directed vectors with hand-computed expectations.
module tb_latch_load_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rs[3];
  logic       iv[3];
  logic [7:0] di[3];

  logic       ir0, ir1, ir2, en0, en1, en2, bz0, bz1, bz2;
  logic [7:0] dq0, dq1, dq2;
  logic [15:0] lc0, lc1;
  logic [3:0]  lc2;

  latch_load_sequencer u0 (
    .clk(clk), .rst(rs[0]), .in_valid(iv[0]), .in_ready(ir0), .d_in(di[0]),
    .d_out(dq0), .EN(en0), .busy(bz0), .load_count(lc0));

  latch_load_sequencer #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) u1 (
    .clk(clk), .rst(rs[1]), .in_valid(iv[1]), .in_ready(ir1), .d_in(di[1]),
    .d_out(dq1), .EN(en1), .busy(bz1), .load_count(lc1));

  latch_load_sequencer #(.CNT_W(4)) u2 (
    .clk(clk), .rst(rs[2]), .in_valid(iv[2]), .in_ready(ir2), .d_in(di[2]),
    .d_out(dq2), .EN(en2), .busy(bz2), .load_count(lc2));

  // Timing model: each accepted byte occupies S+P+H edges; EN is high while
  // the age since the accept lies in [S, S+P); the count bumps at age S+P.
  int S[3]  = '{1, 3, 1};
  int P[3]  = '{2, 1, 2};
  int H[3]  = '{1, 2, 1};
  int CW[3] = '{16, 16, 4};

  bit         mbusy[3];
  int         age[3];
  logic [7:0] mdout[3];
  int         mcnt[3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rs[i]) begin
        mbusy[i] <= 1'b0;
        age[i]   <= 0;
        mdout[i] <= 8'h00;
        mcnt[i]  <= 0;
      end else if (!mbusy[i]) begin
        if (iv[i]) begin
          mbusy[i] <= 1'b1;
          age[i]   <= 0;
          mdout[i] <= di[i];
        end
      end else begin
        age[i] <= age[i] + 1;
        if (age[i] + 1 == S[i] + P[i]) mcnt[i] <= (mcnt[i] + 1) % (1 << CW[i]);
        if (age[i] + 1 == S[i] + P[i] + H[i]) mbusy[i] <= 1'b0;
      end
    end
  end

  int checks = 0;
  int failures = 0;
  int en_hi0 = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t actual=%0h required=%0h", nm, inst, $time, act, exp);
    end
  endtask

  task automatic cmp_all();
    logic        a_ir[3], a_en[3], a_bz[3];
    logic [7:0]  a_dq[3];
    logic [15:0] a_lc[3];
    bit          e_en;
    a_ir = '{ir0, ir1, ir2};
    a_en = '{en0, en1, en2};
    a_bz = '{bz0, bz1, bz2};
    a_dq = '{dq0, dq1, dq2};
    a_lc = '{lc0, lc1, {12'h000, lc2}};
    for (int i = 0; i < 3; i++) begin
      e_en = mbusy[i] && (age[i] >= S[i]) && (age[i] < S[i] + P[i]);
      chk("m_in_ready", i, 32'(a_ir[i]), 32'(!mbusy[i] && !rs[i]));
      chk("m_busy",     i, 32'(a_bz[i]), 32'(mbusy[i]));
      chk("m_en",       i, 32'(a_en[i]), 32'(e_en));
      chk("m_d_out",    i, 32'(a_dq[i]), 32'(mdout[i]));
      chk("m_count",    i, 32'(a_lc[i]), 32'(mcnt[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cmp_all();
    if (en0) en_hi0++;
  endtask

  task automatic wait_idle0(input int bound);
    int n = 0;
    while (bz0 && n < bound) begin
      step();
      n++;
    end
    if (bz0) chk("idle_timeout", 0, 32'(bz0), 32'd0);
  endtask

  initial begin
    int acc[$];
    int n, base, hi_start, accs, pulses;
    bit hs, prev;

    for (int i = 0; i < 3; i++) begin
      rs[i] = 1'b1; iv[i] = 1'b0; di[i] = 8'h00;
    end
    step();
    step();
    chk("rst_ready", 0, 32'(ir0), 32'd0);
    chk("rst_en",    0, 32'(en0), 32'd0);
    chk("rst_dout",  0, 32'(dq0), 32'h00);
    chk("rst_count", 0, 32'(lc0), 32'd0);
    for (int i = 0; i < 3; i++) rs[i] = 1'b0;

    // Single load of A5 accepted at edge 0.
    iv[0] = 1'b1; di[0] = 8'hA5;
    step();
    iv[0] = 1'b0;
    chk("single_dout_e0", 0, 32'(dq0), 32'hA5);
    chk("single_en_e0",   0, 32'(en0), 32'd0);
    step();
    chk("single_en_e1",   0, 32'(en0), 32'd1);
    step();
    chk("single_en_e2",   0, 32'(en0), 32'd1);
    step();
    chk("single_en_e3",   0, 32'(en0), 32'd0);
    chk("single_cnt_e3",  0, 32'(lc0), 32'd1);
    step();
    chk("single_rdy_e4",  0, 32'(ir0), 32'd1);
    chk("single_cnt_e4",  0, 32'(lc0), 32'd1);

    // Back-to-back: 3C then C3 with in_valid held high.
    base = int'(lc0); hi_start = en_hi0;
    iv[0] = 1'b1; di[0] = 8'h3C; n = 0;
    while (acc.size() < 2 && n < 40) begin
      hs = iv[0] && ir0;
      step();
      if (hs) begin
        acc.push_back(n);
        if (acc.size() == 1) di[0] = 8'hC3;
        else iv[0] = 1'b0;
      end
      n++;
    end
    iv[0] = 1'b0;
    chk("b2b_accepts", 0, 32'(acc.size()), 32'd2);
    if (acc.size() == 2) chk("b2b_spacing", 0, 32'(acc[1] - acc[0]), 32'd5);
    wait_idle0(20);
    chk("b2b_dout",   0, 32'(dq0), 32'hC3);
    chk("b2b_count",  0, 32'(int'(lc0) - base), 32'd2);
    chk("b2b_en_cyc", 0, 32'(en_hi0 - hi_start), 32'd4);

    // Busy ignore: FF offered for one cycle during PULSE.
    step();
    base = int'(lc0); hi_start = en_hi0;
    iv[0] = 1'b1; di[0] = 8'h3C;
    step();
    iv[0] = 1'b0;
    step();
    chk("ign_en_pulse", 0, 32'(en0), 32'd1);
    iv[0] = 1'b1; di[0] = 8'hFF;
    step();
    iv[0] = 1'b0; di[0] = 8'h00;
    chk("ign_dout", 0, 32'(dq0), 32'h3C);
    wait_idle0(20);
    step();
    step();
    chk("ign_dout_end", 0, 32'(dq0), 32'h3C);
    chk("ign_count",    0, 32'(int'(lc0) - base), 32'd1);
    chk("ign_en_cyc",   0, 32'(en_hi0 - hi_start), 32'd2);
    chk("ign_idle",     0, 32'(bz0), 32'd0);

    // Reset while EN is high.
    iv[0] = 1'b1; di[0] = 8'h5A;
    step();
    iv[0] = 1'b0;
    step();
    chk("rstmid_en_before", 0, 32'(en0), 32'd1);
    rs[0] = 1'b1;
    step();
    chk("rstmid_en",    0, 32'(en0), 32'd0);
    chk("rstmid_dout",  0, 32'(dq0), 32'h00);
    chk("rstmid_count", 0, 32'(lc0), 32'd0);
    chk("rstmid_busy",  0, 32'(bz0), 32'd0);
    rs[0] = 1'b0;
    step();
    chk("rstmid_ready", 0, 32'(ir0), 32'd1);

    // Timing sweep on the 3/1/2 instance: load 81 at edge 0.
    iv[1] = 1'b1; di[1] = 8'h81;
    step();
    iv[1] = 1'b0;
    chk("sweep_dout", 1, 32'(dq1), 32'h81);
    for (int e = 1; e <= 6; e++) begin
      step();
      chk("sweep_en",    1, 32'(en1), 32'(e == 3));
      chk("sweep_ready", 1, 32'(ir1), 32'(e >= 6));
    end
    chk("sweep_count", 1, 32'(lc1), 32'd1);

    // Counter wrap on the 4-bit instance: 17 loads, in_valid held high.
    iv[2] = 1'b1; di[2] = 8'h01;
    accs = 0; pulses = 0; n = 0; prev = en2;
    while (pulses < 17 && n < 300) begin
      hs = iv[2] && ir2;
      step();
      n++;
      if (hs) begin
        accs++;
        if (accs == 17) iv[2] = 1'b0;
        else di[2] = 8'(accs + 1);
      end
      if (prev && !en2) begin
        pulses++;
        if (pulses == 15) chk("wrap_15", 2, 32'(lc2), 32'd15);
        if (pulses == 16) chk("wrap_16", 2, 32'(lc2), 32'd0);
        if (pulses == 17) chk("wrap_17", 2, 32'(lc2), 32'd1);
      end
      prev = en2;
    end
    iv[2] = 1'b0;
    chk("wrap_pulses", 2, 32'(pulses), 32'd17);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
